// File: rtl/wc_sf1_cii_cell_pkg.sv
// Shared wrapper-cell definitions: mode encoding, control decode and reset value.
package wc_pkg;

    typedef enum logic [1:0] {
        WC_CAPTURE = 2'd0,
        WC_SHIFT   = 2'd1,
        WC_HOLD    = 2'd2
    } wc_mode_e;

    localparam logic WC_RESET_VAL = 1'b0;

    // Ternaries rather than if/else so an unknown control propagates into the mode.
    function automatic wc_mode_e wc_decode(input logic scan_en, input logic hold_en);
        return hold_en ? WC_HOLD : (scan_en ? WC_SHIFT : WC_CAPTURE);
    endfunction

endpackage

// File: rtl/wc_sf1_cii_cell_if.sv
// Functional and serial-scan signals of the wrapper-cell bank.
interface wc_sf1_cii_cell_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] CFI;
    logic             CTI;
    logic             ScanEnable;
    logic             HoldEnable;
    logic [WIDTH-1:0] CFO;
    logic             CTO;

    modport master (
        output CFI, CTI, ScanEnable, HoldEnable,
        input  CFO, CTO
    );

    modport slave (
        input  CFI, CTI, ScanEnable, HoldEnable,
        output CFO, CTO
    );
endinterface

// File: rtl/wc_sf1_cii_cell_bit.sv
// One wrapper cell: a single shift-flop with its capture/shift/hold selection.
module wc_sf1_cii_bit
    import wc_pkg::*;
(
    input  logic     clk_i,
    input  logic     reset_i,
    input  wc_mode_e mode_i,
    input  logic     cfi_i,
    input  logic     shift_i,
    output logic     sf_o
);

    logic sf_q;
    logic sf_d;

    always_comb begin
        sf_d = (mode_i == WC_HOLD)  ? sf_q :
               (mode_i == WC_SHIFT) ? shift_i : cfi_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sf_q <= WC_RESET_VAL;
        end else begin
            sf_q <= sf_d;
        end
    end

    assign sf_o = sf_q;

endmodule

// File: rtl/wc_sf1_cii_cell.sv
// Bank of WIDTH wrapper cells chained CTI -> SF[0] -> ... -> SF[WIDTH-1] -> CTO.
// Optional macro WC_SF1_CII_CFO_DRIVE_EN: CFO shows the stored SF while HoldEnable=1.
module wc_sf1_cii_cell
    import wc_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic               CLK,
    input  logic               reset,
    wc_sf1_cii_cell_if.slave   bus
);

    wc_mode_e         mode;
    logic [WIDTH-1:0] sf;

    assign mode = wc_decode(bus.ScanEnable, bus.HoldEnable);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic shift_src;

        if (i == 0) begin : g_head
            assign shift_src = bus.CTI;
        end else begin : g_tail
            assign shift_src = sf[i-1];
        end

        wc_sf1_cii_bit u_bit (
            .clk_i   (CLK),
            .reset_i (reset),
            .mode_i  (mode),
            .cfi_i   (bus.CFI[i]),
            .shift_i (shift_src),
            .sf_o    (sf[i])
        );
    end

    assign bus.CTO = sf[WIDTH-1];

`ifdef WC_SF1_CII_CFO_DRIVE_EN
    assign bus.CFO = bus.HoldEnable ? sf : bus.CFI;
`else
    assign bus.CFO = bus.CFI;
`endif

endmodule

// File: tb/tb_wc_sf1_cii_cell.sv
// Self-checking bench for wc_sf1_cii_cell with a 1-cell and a 4-cell bank.
module tb_wc_sf1_cii_cell;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic q1[$];
    logic q4[$];

    always #5 clk = ~clk;

    wc_sf1_cii_cell_if #(.WIDTH(1)) if1 ();
    wc_sf1_cii_cell_if #(.WIDTH(4)) if4 ();

    wc_sf1_cii_cell #(.WIDTH(1)) dut1 (.CLK(clk), .reset(rst), .bus(if1));
    wc_sf1_cii_cell #(.WIDTH(4)) dut4 (.CLK(clk), .reset(rst), .bus(if4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic       v1;
        logic [3:0] v4;
        rst = 1'b1;
        if1.ScanEnable = 1'b1; if1.HoldEnable = 1'b0; if1.CTI = 1'b1;
        if4.ScanEnable = 1'b1; if4.HoldEnable = 1'b0; if4.CTI = 1'b1;
        for (int i = 0; i < 3; i++) begin
            v1 = i[0];
            v4 = 4'(i * 5 + 3);
            if1.CFI = v1;
            if4.CFI = v4;
            tick();
            checks++;
            if (if1.CTO !== 1'b0) begin
                errors++; $display("FAIL reset_cto1 cyc %0d got %b exp 0", i, if1.CTO);
            end
            checks++;
            if (if4.CTO !== 1'b0) begin
                errors++; $display("FAIL reset_cto4 cyc %0d got %b exp 0", i, if4.CTO);
            end
            checks++;
            if (if4.CFO !== v4) begin
                errors++; $display("FAIL reset_cfo4 cyc %0d got %h exp %h", i, if4.CFO, v4);
            end
        end
        // All-zero shift-out after release proves every SF bit was cleared.
        rst = 1'b0;
        if4.CTI = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (if4.CTO !== 1'b0) begin
                errors++; $display("FAIL reset_sf4 cyc %0d got %b exp 0", i, if4.CTO);
            end
        end
    endtask

    task automatic test_capture();
        logic       exp;
        logic [3:0] v4;
        if1.ScanEnable = 1'b0; if1.HoldEnable = 1'b0;
        if4.ScanEnable = 1'b0; if4.HoldEnable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if1.CFI = ~i[0];
            q1.push_back(~i[0]);
            v4 = 4'($urandom);
            if4.CFI = v4;
            q4.push_back(v4[3]);
            tick();
            exp = q1.pop_front();
            checks++;
            if (if1.CTO !== exp) begin
                errors++; $display("FAIL capture_cto1 cyc %0d got %b exp %b", i, if1.CTO, exp);
            end
            exp = q4.pop_front();
            checks++;
            if (if4.CTO !== exp) begin
                errors++; $display("FAIL capture_cto4 cyc %0d got %b exp %b", i, if4.CTO, exp);
            end
        end
    endtask

    task automatic test_hold();
        if1.ScanEnable = 1'b0; if1.HoldEnable = 1'b0; if1.CFI = 1'b1;
        tick();
        checks++;
        if (if1.CTO !== 1'b1) begin
            errors++; $display("FAIL hold_load got %b exp 1", if1.CTO);
        end
        if1.HoldEnable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if1.ScanEnable = (i >= 10);
            if1.CFI = i[0];
            if1.CTI = i[0];
            tick();
            checks++;
            if (if1.CTO !== 1'b1) begin
                errors++; $display("FAIL hold_cto1 cyc %0d got %b exp 1", i, if1.CTO);
            end
        end
        if1.HoldEnable = 1'b0;
    endtask

    task automatic test_macro();
        logic [3:0] exp_cfo;
`ifdef WC_SF1_CII_CFO_DRIVE_EN
        exp_cfo = 4'hA;
`else
        exp_cfo = 4'h5;
`endif
        if4.ScanEnable = 1'b0; if4.HoldEnable = 1'b0; if4.CFI = 4'hA;
        tick();
        if4.HoldEnable = 1'b1;
        if4.CFI = 4'h5;
        #1;
        checks++;
        if (if4.CFO !== exp_cfo) begin
            errors++; $display("FAIL macro_cfo got %h exp %h", if4.CFO, exp_cfo);
        end
        tick();
        checks++;
        if (if4.CFO !== exp_cfo) begin
            errors++; $display("FAIL macro_cfo_held got %h exp %h", if4.CFO, exp_cfo);
        end
        checks++;
        if (if4.CTO !== 1'b1) begin
            errors++; $display("FAIL macro_cto got %b exp 1", if4.CTO);
        end
        if4.HoldEnable = 1'b0;
        #1;
        checks++;
        if (if4.CFO !== 4'h5) begin
            errors++; $display("FAIL macro_cfo_release got %h exp 5", if4.CFO);
        end
    endtask

    task automatic test_shift();
        logic [7:0] seq;
        logic       exp;
        seq = 8'b0100_1101;
        if4.ScanEnable = 1'b0; if4.HoldEnable = 1'b0; if4.CFI = 4'b0110;
        tick();
        q4.delete();
        // Preloaded SF[2], SF[1], SF[0] leave CTO before the first CTI bit.
        q4.push_back(1'b1);
        q4.push_back(1'b1);
        q4.push_back(1'b0);
        if4.ScanEnable = 1'b1;
        for (int i = 0; i < 11; i++) begin
            if4.CTI = (i < 8) ? seq[i] : 1'b0;
            q4.push_back(if4.CTI);
            if4.CFI = 4'($urandom);
            tick();
            exp = q4.pop_front();
            checks++;
            if (if4.CTO !== exp) begin
                errors++; $display("FAIL shift_cto4 edge %0d got %b exp %b", i + 1, if4.CTO, exp);
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        if4.ScanEnable = 1'b0; if4.HoldEnable = 1'b0; if4.CFI = 4'hF;
        tick();
        if4.ScanEnable = 1'b1; if4.CTI = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (if4.CTO !== 1'b0) begin
            errors++; $display("FAIL midreset_cto got %b exp 0", if4.CTO);
        end
        rst = 1'b0;
        if4.CTI = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (if4.CTO !== 1'b0) begin
                errors++; $display("FAIL midreset_shift cyc %0d got %b exp 0", i, if4.CTO);
            end
        end
    endtask

    task automatic test_x_in_reset();
        if1.HoldEnable = 1'b0; if1.ScanEnable = 1'b0; if1.CFI = 1'b1;
        if4.HoldEnable = 1'b0; if4.ScanEnable = 1'b0; if4.CFI = 4'hF;
        tick();
        rst = 1'b1;
        if1.ScanEnable = 1'bx; if1.HoldEnable = 1'bz;
        if4.ScanEnable = 1'bz; if4.HoldEnable = 1'bx;
        tick();
        checks++;
        if (if1.CTO !== 1'b0) begin
            errors++; $display("FAIL xreset_cto1 got %b exp 0", if1.CTO);
        end
        checks++;
        if (if4.CTO !== 1'b0) begin
            errors++; $display("FAIL xreset_cto4 got %b exp 0", if4.CTO);
        end
        if1.ScanEnable = 1'b0; if1.HoldEnable = 1'b0;
        if4.ScanEnable = 1'b0; if4.HoldEnable = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        if1.CFI = '0; if1.CTI = 1'b0; if1.ScanEnable = 1'b0; if1.HoldEnable = 1'b0;
        if4.CFI = '0; if4.CTI = 1'b0; if4.ScanEnable = 1'b0; if4.HoldEnable = 1'b0;
        test_reset();
        test_capture();
        test_hold();
        test_macro();
        test_shift();
        test_reset_mid_shift();
        test_x_in_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule

// File: doc/wc_sf1_cii_cell.md
WC_SF1_CII_CELL -- requirements
Module: wc_sf1_cii_cell

Interface
- REQ-001 Parameter WIDTH, default 1: number of wrapper cells in the bank, each with one shift-flop storage element (SF); legal range 1..64.
- REQ-002 CLK  input  1: single clock; all state updates on the rising edge.
- REQ-003 reset  input  1: synchronous, active-high reset, sampled on the CLK rising edge.
- REQ-004 CFI  input  WIDTH: functional input; the capture source.
- REQ-005 CTI  input  1: test (serial scan) input into SF[0].
- REQ-006 ScanEnable  input  1: 1 selects shift, 0 selects capture, when HoldEnable=0.
- REQ-007 HoldEnable  input  1: 1 freezes SF contents; it overrides ScanEnable.
- REQ-008 CFO  output  WIDTH: functional output.
- REQ-009 CTO  output  1: test (serial scan) output, equal to SF[WIDTH-1].

Function
- REQ-010 Mode decode SHALL be priority-based: HoldEnable=1 gives HOLD; otherwise ScanEnable=1 gives SHIFT; otherwise CAPTURE.
- REQ-011 CAPTURE: on each rising edge, SF[i] <= CFI[i] for all i.
- REQ-012 SHIFT: on each rising edge, SF[0] <= CTI and SF[i] <= SF[i-1] for i>0; latency is WIDTH cycles from CTI to CTO.
- REQ-013 HOLD: SF is unchanged on each rising edge, for any ScanEnable value.
- REQ-014 CTO SHALL be a registered output taken directly from SF[WIDTH-1]; there is no combinational path from CTI.
- REQ-015 CFO SHALL equal CFI combinationally (transparent input cell), except as stated in REQ-022.
- REQ-016 Mode changes take effect on the first rising edge after the control inputs change; there are no pipeline stages in the decode.
- REQ-017 An X or Z on ScanEnable or HoldEnable while reset=1 SHALL NOT affect SF.
- REQ-018 An X on ScanEnable or HoldEnable outside reset SHALL propagate X into SF; the block performs no masking.

Reset
- REQ-019 reset=1 at a rising edge SHALL clear all SF bits to 0, so CTO=0; reset has priority over every mode.
- REQ-020 Reset asserted mid-shift or mid-hold SHALL discard the contents; after release, operation restarts from SF=0.
- REQ-021 CFO has no reset value; it follows CFI during reset (or per REQ-022).

Configuration
- REQ-022 Macro WC_SF1_CII_CFO_DRIVE_EN selects how CFO is driven:
  - Defined: CFO = SF whenever HoldEnable=1, otherwise CFO = CFI.
  - Undefined: CFO = CFI at all times, and no storage-to-CFO path exists.

Structure
- REQ-023 A shared package wc_pkg SHALL hold:
  - the mode enum {WC_CAPTURE, WC_SHIFT, WC_HOLD};
  - the decode function mapping (ScanEnable, HoldEnable) to the mode;
  - the constant WC_RESET_VAL = 0.
- REQ-024 One sub-module, wc_sf1_cii_bit, SHALL implement a single cell (SF flop plus its capture/shift/hold mux); the top instantiates it WIDTH times as a chain.

Verification
- REQ-025 Reset: reset=1 for 3 cycles with CFI toggling -> CTO=0 and SF=0 throughout; CFO tracks CFI.
- REQ-026 Capture: WIDTH=1, reset=0, SE=0, HE=0, CFI toggling every 10 ns on a 10 ns clock -> CTO equals the CFI value sampled at the previous edge.
- REQ-027 Hold: capture CFI=1, then HE=1 for 10 cycles with SE=0 and then SE=1 while CFI and CTI toggle -> CTO stays 1.
- REQ-028 Shift: WIDTH=4, SE=1, HE=0, CTI sequence 1,0,1,1 -> CTO shows 1,0,1,1 starting on the 4th edge.
- REQ-029 Macro: with WC_SF1_CII_CFO_DRIVE_EN defined, capture CFI=4'hA, then HE=1 and CFI=4'h5 -> CFO=4'hA; without the macro -> CFO=4'h5.
- REQ-030 Reset mid-shift: after 2 shift cycles of 1s with WIDTH=4, assert reset for 1 cycle, then shift 4 zeros -> CTO stays 0.
